fb_writer: RTL and testbench

Frame-buffer writer: the producer side of the pixel memory that the VGA scan-out path reads. Accepts a ready/valid stream of 24-bit RGB pixels in raster order and packs two pixels per 192-bit vector word. Writes each word into the data memory at the word address that scan-out uses, `base + y*3*IMG_W + x*3`. Sits between the vector-processor result path and the data memory's vector write port, one frame per `start`.

---
 rtl/fb_pkg.sv | 32 +++
 rtl/fb_writer.sv | 136 +++++++++++++
 tb/tb_fb_writer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants, types and lane packing for the frame-buffer writer
//
// Contents:
//   LANES, LANE_W, WORDS_PER_PIX : vector word geometry (6 x 32-bit lanes, 3 words per pixel)
//   fb_state_t                   : writer FSM states
//   rgb_t                        : packed r/g/b pixel
//   pack_lane()                  : places one colour byte in the low bits of a zeroed lane
package fb_pkg;

   localparam int LANES         = 6;
   localparam int LANE_W        = 32;
   localparam int WORDS_PER_PIX = 3;

   typedef enum logic [2:0] {
      IDLE,
      FILL0,
      FILL1,
      WRITE,
      DONE
   } fb_state_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   function automatic logic [LANE_W-1:0] pack_lane(input logic [7:0] i_byte);
      return {{(LANE_W-8){1'b0}}, i_byte};
   endfunction

endpackage

// File: rtl/fb_writer.sv
// rtl/fb_writer.sv - packs a raster pixel stream two pixels per 192-bit word into the frame buffer
//
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   start, busy         : begin a frame (taken only when idle) / frame in progress
//   frame_done          : one-cycle pulse after the last word write is accepted
//   pix_valid/pix_ready : pixel stream handshake, data on pix_r/pix_g/pix_b
//   mem_we, mem_isVector, mem_address, mem_wd : vector write request to data memory
//   mem_busy            : memory stall; the request is held while high
module fb_writer
   import fb_pkg::*;
#(
   parameter int          IMG_W     = 100,
   parameter int          IMG_H     = 100,
   parameter logic [31:0] BASE_ADDR = 32'd0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   output logic                     frame_done,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   input  logic [7:0]               pix_r,
   input  logic [7:0]               pix_g,
   input  logic [7:0]               pix_b,
   output logic                     mem_we,
   output logic                     mem_isVector,
   output logic [31:0]              mem_address,
   output logic [LANES*LANE_W-1:0]  mem_wd,
   input  logic                     mem_busy
);

   localparam int N_PIX   = IMG_W * IMG_H;
   localparam int N_WORDS = (N_PIX + 1) / 2;
   localparam int PW      = $clog2(N_PIX + 1);
   localparam int WW      = $clog2(N_WORDS + 1);

   localparam logic [PW-1:0] LAST_PIX  = PW'(N_PIX - 1);
   localparam logic [WW-1:0] LAST_WORD = WW'(N_WORDS - 1);

   fb_state_t       r_state;
   fb_state_t       w_next;
   logic [PW-1:0]   r_pix_cnt;
   logic [WW-1:0]   r_word_cnt;
   rgb_t            r_pix0;
   rgb_t            r_pix1;

   logic            w_pix_hs;
   logic            w_wr_acc;
   logic            w_last_pix;
   logic            w_last_word;
   logic [31:0]     w_off4;
   logic [31:0]     w_off2;

   assign w_pix_hs    = pix_valid & pix_ready;
   assign w_wr_acc    = mem_we & ~mem_busy;
   assign w_last_pix  = (r_pix_cnt == LAST_PIX);
   assign w_last_word = (r_word_cnt == LAST_WORD);

   // word_cnt*6 as word_cnt*4 + word_cnt*2
   assign w_off4 = 32'({r_word_cnt, 2'b00});
   assign w_off2 = 32'({r_word_cnt, 1'b0});

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      pix_ready  = 1'b0;
      mem_we     = 1'b0;
      frame_done = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_next = FILL0;
         end
         FILL0: begin
            pix_ready = 1'b1;
            // an odd-sized frame ends on a half-filled word
            if (pix_valid) w_next = w_last_pix ? WRITE : FILL1;
         end
         FILL1: begin
            pix_ready = 1'b1;
            if (pix_valid) w_next = WRITE;
         end
         WRITE: begin
            mem_we = 1'b1;
            if (!mem_busy) w_next = w_last_word ? DONE : FILL0;
         end
         DONE: begin
            frame_done = 1'b1;
            w_next     = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pix_cnt  <= '0;
         r_word_cnt <= '0;
         r_pix0     <= '0;
         r_pix1     <= '0;
      end else begin
         if (r_state == IDLE && start) begin
            r_pix_cnt  <= '0;
            r_word_cnt <= '0;
         end
         if (w_pix_hs) begin
            r_pix_cnt <= r_pix_cnt + PW'(1);
            if (r_state == FILL0) begin
               r_pix0 <= '{r: pix_r, g: pix_g, b: pix_b};
               if (w_last_pix) r_pix1 <= '0;
            end else begin
               r_pix1 <= '{r: pix_r, g: pix_g, b: pix_b};
            end
         end
         if (w_wr_acc) begin
            r_word_cnt <= r_word_cnt + WW'(1);
         end
      end
   end

   assign busy         = (r_state != IDLE);
   assign mem_isVector = 1'b1;
   assign mem_address  = BASE_ADDR + w_off4 + w_off2;
   // lane 0 is the low 32 bits: r0, g0, b0, r1, g1, b1
   assign mem_wd = {pack_lane(r_pix1.b), pack_lane(r_pix1.g), pack_lane(r_pix1.r),
                    pack_lane(r_pix0.b), pack_lane(r_pix0.g), pack_lane(r_pix0.r)};

endmodule

// File: tb/tb_fb_writer.sv
// tb/tb_fb_writer.sv - self-checking bench for fb_writer
module tb_fb_writer;

   localparam int          W      = 100;
   localparam int          H      = 100;
   localparam int          N      = W * H;
   localparam int          NW     = (N + 1) / 2;
   localparam logic [31:0] BASE_B = 32'd30000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetn;
   logic          start;
   logic          pix_valid;
   logic          mem_busy;
   logic [7:0]    pix_r, pix_g, pix_b;
   logic          busy, frame_done, pix_ready, mem_we, mem_isVector;
   logic [31:0]   mem_address;
   logic [191:0]  mem_wd;

   logic          b_busy, b_frame_done, b_pix_ready, b_mem_we, b_mem_isVector;
   logic [31:0]   b_mem_address;
   logic [191:0]  b_mem_wd;

   logic          s_start, s_pix_valid, s_mem_busy;
   logic [7:0]    s_r, s_g, s_b;
   logic          s_busy, s_frame_done, s_pix_ready, s_mem_we, s_mem_isVector;
   logic [31:0]   s_mem_address;
   logic [191:0]  s_mem_wd;

   fb_writer #(.IMG_W(W), .IMG_H(H), .BASE_ADDR(32'd0)) u_dut (
      .clk(clk), .reset(resetn), .start(start), .busy(busy), .frame_done(frame_done),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .mem_we(mem_we), .mem_isVector(mem_isVector), .mem_address(mem_address), .mem_wd(mem_wd),
      .mem_busy(mem_busy));

   fb_writer #(.IMG_W(W), .IMG_H(H), .BASE_ADDR(BASE_B)) u_base (
      .clk(clk), .reset(resetn), .start(start), .busy(b_busy), .frame_done(b_frame_done),
      .pix_valid(pix_valid), .pix_ready(b_pix_ready), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .mem_we(b_mem_we), .mem_isVector(b_mem_isVector), .mem_address(b_mem_address), .mem_wd(b_mem_wd),
      .mem_busy(mem_busy));

   fb_writer #(.IMG_W(3), .IMG_H(1), .BASE_ADDR(32'd0)) u_small (
      .clk(clk), .reset(resetn), .start(s_start), .busy(s_busy), .frame_done(s_frame_done),
      .pix_valid(s_pix_valid), .pix_ready(s_pix_ready), .pix_r(s_r), .pix_g(s_g), .pix_b(s_b),
      .mem_we(s_mem_we), .mem_isVector(s_mem_isVector), .mem_address(s_mem_address), .mem_wd(s_mem_wd),
      .mem_busy(s_mem_busy));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // pixel p of a frame with colour offset o: (p+o, p+o+1, p+o+2) mod 256
   function automatic logic [23:0] pix(input int p, input int o);
      logic [7:0] r;
      r = 8'(p + o);
      return {r, 8'(r + 8'd1), 8'(r + 8'd2)};
   endfunction

   // expected vector word j of a 100x100 frame
   function automatic logic [191:0] exp_word(input int j, input int o);
      logic [23:0] p0, p1;
      p0 = pix(2 * j, o);
      p1 = (2 * j + 1 < N) ? pix(2 * j + 1, o) : 24'd0;
      return {24'd0, p1[7:0], 24'd0, p1[15:8], 24'd0, p1[23:16],
              24'd0, p0[7:0], 24'd0, p0[15:8], 24'd0, p0[23:16]};
   endfunction

   // ---------------- stimulus driver (pixel stream and memory stalls) ----------------
   int drv_mode   = 0;   // 0 off, 1 valid always, 2 valid random
   int ofs        = 0;
   int next_p     = 0;
   int stall_left = 0;
   int busy_pct   = 0;
   bit hs_flag    = 1'b0;

   // ---------------- scoreboard state ----------------
   int exp_j = 0, pix_in = 0, done_cnt = 0, cyc = 0, start_cyc = -10;
   int last_hs_cyc = 0, stalls_after = 0, stall0 = 0;
   bit chk_on = 1'b0, prev_stall = 1'b0, prev_pair = 1'b0;
   logic [31:0]  prev_addr = '0, last_addr = '0, first_b_addr = '0, last_b_addr = '0, first_addr = '1;
   logic [191:0] prev_wd = '0, w127 = '0;

   initial begin
      pix_valid = 1'b0;
      mem_busy  = 1'b0;
      {pix_r, pix_g, pix_b} = 24'd0;
      forever begin
         @(posedge clk);
         #1;
         if (drv_mode == 0) begin
            next_p    = 0;
            pix_valid = 1'b0;
         end else begin
            if (hs_flag) next_p++;
            pix_valid = (drv_mode == 1) ? 1'b1 : ($urandom_range(0, 1) == 1);
         end
         {pix_r, pix_g, pix_b} = pix(next_p, ofs);
         if (mem_we && stall_left > 0) begin
            mem_busy = 1'b1;
            stall_left--;
         end else begin
            mem_busy = mem_we && busy_pct > 0 && exp_j > 0 && ($urandom_range(0, 99) < busy_pct);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      cyc++;
      hs_flag = 1'b0;
      if (!resetn) begin
         exp_j      = 0;
         pix_in     = 0;
         prev_stall = 1'b0;
         prev_pair  = 1'b0;
      end else if (chk_on) begin
         check("isvector", mem_isVector, 1);
         if (!busy && start) begin
            start_cyc = cyc;
            exp_j     = 0;
            pix_in    = 0;
            stall0    = 0;
         end
         if (cyc == start_cyc + 1) begin
            check("ready_after_start", pix_ready, 1);
            check("busy_after_start", busy, 1);
         end
         if (prev_stall) begin
            check("stall_we", mem_we, 1);
            check("stall_addr", mem_address, prev_addr);
            check("stall_data", mem_wd, prev_wd);
         end
         if (prev_pair) check("we_after_pair", mem_we, 1);
         if (mem_we) check("ready_in_write", pix_ready, 0);
         if (mem_we && mem_busy) begin
            stalls_after++;
            if (exp_j == 0) stall0++;
         end
         prev_stall = mem_we && mem_busy;
         prev_addr  = mem_address;
         prev_wd    = mem_wd;
         if (mem_we && !mem_busy) begin
            check("wr_addr", mem_address, 32'(6 * exp_j));
            check("wr_data", mem_wd, exp_word(exp_j, ofs));
            check("base_we", b_mem_we, 1);
            check("base_addr", b_mem_address, BASE_B + 32'(6 * exp_j));
            check("base_data", b_mem_wd, exp_word(exp_j, ofs));
            if (exp_j == 0) begin
               first_addr   = mem_address;
               first_b_addr = b_mem_address;
            end
            if (exp_j == 127) w127 = mem_wd;
            last_addr   = mem_address;
            last_b_addr = b_mem_address;
            exp_j++;
         end
         prev_pair = 1'b0;
         if (pix_valid && pix_ready) begin
            hs_flag      = 1'b1;
            prev_pair    = (pix_in % 2 == 1) || (pix_in == N - 1);
            pix_in++;
            last_hs_cyc  = cyc;
            stalls_after = 0;
         end
         if (frame_done) begin
            done_cnt++;
            check("done_busy", busy, 1);
            check("done_words", exp_j, NW);
            check("done_pixels", pix_in, N);
            // last pixel cycle, then WRITE (plus any stalls), then DONE
            check("done_latency", cyc - last_hs_cyc, 2 + stalls_after);
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, frame_done, 0);
      check({tag, "_ready"}, pix_ready, 0);
      check({tag, "_we"}, mem_we, 0);
      check({tag, "_addr"}, mem_address, 32'd0);
      check({tag, "_wd"}, mem_wd, 192'd0);
      check({tag, "_isvec"}, mem_isVector, 1);
      check({tag, "_base_addr"}, b_mem_address, BASE_B);
      check({tag, "_base_we"}, b_mem_we, 0);
   endtask

   task automatic wait_done(input string tag, input int limit);
      int d0;
      d0 = done_cnt;
      for (int c = 0; c < limit && done_cnt == d0; c++) @(posedge clk);
      check({tag, "_frame_done_seen"}, done_cnt, d0 + 1);
      repeat (4) @(posedge clk);
      check({tag, "_frame_done_once"}, done_cnt, d0 + 1);
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0]  s_tab [3];
      logic [31:0]  s_addr [2];
      logic [191:0] s_wd [2];
      int s_k, s_wn, s_done, d0;

      resetn = 1'b0;
      start = 1'b0;
      s_start = 1'b0;
      s_pix_valid = 1'b0;
      s_mem_busy = 1'b0;
      {s_r, s_g, s_b} = 24'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("rst0");
      check("rst0_small_wd", s_mem_wd, 192'd0);
      @(posedge clk);
      #1 resetn = 1'b1;
      chk_on = 1'b1;

      // ---- 3x1 frame: odd pixel count, half-filled last word ----
      s_tab[0] = 24'h112233;
      s_tab[1] = 24'h445566;
      s_tab[2] = 24'h778899;
      s_k = 0; s_wn = 0; s_done = 0;
      s_addr[0] = '1; s_addr[1] = '1; s_wd[0] = '1; s_wd[1] = '1;
      @(posedge clk);
      #1 s_start = 1'b1;
      @(posedge clk);
      #1 s_start = 1'b0;
      for (int c = 0; c < 60 && s_done == 0; c++) begin
         s_pix_valid = (s_k < 3);
         {s_r, s_g, s_b} = (s_k < 3) ? s_tab[s_k] : 24'd0;
         @(negedge clk);
         if (s_pix_valid && s_pix_ready) s_k++;
         if (s_mem_we && !s_mem_busy) begin
            if (s_wn < 2) begin
               s_addr[s_wn] = s_mem_address;
               s_wd[s_wn]   = s_mem_wd;
            end
            s_wn++;
         end
         if (s_frame_done) s_done++;
         @(posedge clk);
         #1;
      end
      s_pix_valid = 1'b0;
      check("small_writes", s_wn, 2);
      check("small_addr0", s_addr[0], 32'd0);
      check("small_addr1", s_addr[1], 32'd6);
      check("small_wd0", s_wd[0], {32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11});
      check("small_wd1", s_wd[1], {32'h0, 32'h0, 32'h0, 32'h99, 32'h88, 32'h77});
      check("small_done", s_done, 1);
      @(negedge clk);
      check("small_idle", s_busy, 0);

      // ---- full frame, valid always, no stalls ----
      @(negedge clk);
      ofs = 0; busy_pct = 0; stall_left = 0; drv_mode = 1;
      pulse_start();
      wait_done("f1", 20000);
      check("f1_words", exp_j, 5000);
      check("f1_w127", w127, 192'h00000001_00000000_000000ff_00000000_000000ff_000000fe);
      check("f1_last_addr", last_addr, 32'd29994);
      check("f1_base_first", first_b_addr, 32'd30000);
      check("f1_base_last", last_b_addr, 32'd59994);
      @(negedge clk);
      check("f1_idle", busy, 0);
      drv_mode = 0;

      // ---- reset while filling the second pixel of word 1 ----
      @(negedge clk);
      ofs = 50; drv_mode = 1;
      pulse_start();
      for (int c = 0; c < 50 && pix_in < 3; c++) @(posedge clk);
      #1;
      check("rst_pixels", pix_in, 3);
      check("rst_in_fill1", pix_ready, 1);
      check("rst_in_fill1_we", mem_we, 0);
      resetn = 1'b0;
      drv_mode = 0;
      d0 = done_cnt;
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("rst1");
      @(posedge clk);
      #1 resetn = 1'b1;
      repeat (4) @(posedge clk);
      check("rst_no_done", done_cnt, d0);
      check("rst_no_write", exp_j, 0);

      // ---- random valid, stall on write 0, random stalls, stray start ----
      @(negedge clk);
      ofs = 100; stall_left = 4; busy_pct = 25; drv_mode = 2;
      pulse_start();
      repeat (200) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("f2", 60000);
      check("f2_words", exp_j, 5000);
      check("f2_stall0", stall0, 4);
      check("f2_first_addr", first_addr, 32'd0);
      drv_mode = 0;
      busy_pct = 0;
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
